// File: rtl/route_data_deser_pkg.sv
// Shared definitions for the route-word deserializer: word width, FSM encoding
// and saturating counter helpers.
package route_data_deser_pkg;

  localparam int ROUTE_WORD_W = 28;

  localparam logic [7:0]  CNT8_MAX  = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } route_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/route_data_deser_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pops land in a registered read port.
// i_push / i_pop arrive already qualified against full/empty by the caller.
module route_sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_pop;
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level    = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/route_data_deser.sv
// Rebuilds MSB-first route words from the serial readout link and queues them
// for the framing logic; tracks accepted, truncated and dropped words.
module route_data_deser
  import route_data_deser_pkg::*;
#(
  parameter int WORD_W     = ROUTE_WORD_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_40MHz,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic                          route_data_in,
  input  logic                          rd_en,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   word_cnt,
  output logic [7:0]                    frame_err_cnt,
  output logic [7:0]                    overflow_cnt,
  output route_state_e                  dbg_state
);

  localparam int CW = $clog2(WORD_W + 1);

  route_state_e      r_state;
  route_state_e      w_state_nxt;
  logic [CW-1:0]     r_bit_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [WORD_W-1:0] r_shift;
  logic              r_push_valid;
  logic              w_shift_en;
  logic              w_word_done;
  logic              w_frame_err;
  logic              w_pop;
  logic              w_push;
  logic [15:0]       r_word_cnt;
  logic [7:0]        r_frame_err_cnt;
  logic [7:0]        r_overflow_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_en  = 1'b0;
    w_word_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_in) begin
          w_shift_en  = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (valid_in) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == CW'(WORD_W - 1)) begin
            w_word_done = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_frame_err = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_push_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_cnt_nxt;
      r_push_valid <= w_word_done;
      if (w_shift_en) r_shift <= {r_shift[WORD_W-2:0], route_data_in};
    end
  end

  // The completed word is written from r_shift one edge later; that same edge
  // may already shift in the next word's MSB, but the write sees the old value.
  assign w_pop  = rd_en && !fifo_empty;
  assign w_push = r_push_valid && (!fifo_full || w_pop);

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt      <= '0;
      r_frame_err_cnt <= '0;
      r_overflow_cnt  <= '0;
    end else begin
      if (w_push) r_word_cnt <= r_word_cnt + 16'd1;
      if (r_push_valid && !w_push) r_overflow_cnt <= sat_inc8(r_overflow_cnt);
      if (w_frame_err) r_frame_err_cnt <= sat_inc8(r_frame_err_cnt);
    end
  end

  route_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk_40MHz),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_empty     (fifo_empty),
    .o_full      (fifo_full),
    .o_level     (fifo_level)
  );

  assign word_cnt      = r_word_cnt;
  assign frame_err_cnt = r_frame_err_cnt;
  assign overflow_cnt  = r_overflow_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_route_data_deser.sv
// Bench for route_data_deser: table-driven word vectors, hand-written corner
// sequences and random traffic, all compared against a queue-based model.
`timescale 1ns/1ps
module tb_route_data_deser;
  import route_data_deser_pkg::*;

  localparam int W     = 28;
  localparam int DEPTH = 8;

  logic          clk_40MHz;
  logic          rst_n;
  logic          valid_in;
  logic          route_data_in;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic [3:0]    fifo_level;
  logic [15:0]   word_cnt;
  logic [7:0]    frame_err_cnt;
  logic [7:0]    overflow_cnt;
  route_state_e  dbg_state;

  route_data_deser #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_40MHz     (clk_40MHz),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .route_data_in (route_data_in),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_level    (fifo_level),
    .word_cnt      (word_cnt),
    .frame_err_cnt (frame_err_cnt),
    .overflow_cnt  (overflow_cnt),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk_40MHz = 1'b0;
  always #12 clk_40MHz = ~clk_40MHz;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model: queue of stored words plus plain counters
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_acc;
  int           m_nbits;
  bit           m_pend;
  logic [W-1:0] m_pend_word;
  logic [W-1:0] m_rd_data;
  bit           m_rd_valid;
  logic [15:0]  m_word_cnt;
  logic [7:0]   m_err_cnt;
  logic [7:0]   m_ovf_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc = '0; m_nbits = 0; m_pend = 0; m_pend_word = '0;
    m_rd_data = '0; m_rd_valid = 0;
    m_word_cnt = '0; m_err_cnt = '0; m_ovf_cnt = '0;
  endtask

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    bit pop_ok;
    if (!rst_n) return;
    pop_ok = rd_en && (exp_q.size() > 0);
    m_rd_valid = pop_ok;
    if (pop_ok) m_rd_data = exp_q.pop_front();
    if (m_pend) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(m_pend_word);
        m_word_cnt = m_word_cnt + 16'd1;
      end else if (m_ovf_cnt != 8'hFF) begin
        m_ovf_cnt = m_ovf_cnt + 8'd1;
      end
    end
    m_pend = 0;
    if (valid_in) begin
      m_acc = {m_acc[W-2:0], route_data_in};
      m_nbits++;
      if (m_nbits == W) begin
        m_pend = 1;
        m_pend_word = m_acc;
        m_nbits = 0;
      end
    end else if (m_nbits > 0) begin
      if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
      m_nbits = 0;
    end
  endtask

  task automatic check_all();
    chk("rd_valid",   32'(rd_valid),      32'(m_rd_valid));
    chk("rd_data",    32'(rd_data),       32'(m_rd_data));
    chk("fifo_empty", 32'(fifo_empty),    32'(exp_q.size() == 0));
    chk("fifo_full",  32'(fifo_full),     32'(exp_q.size() == DEPTH));
    chk("fifo_level", 32'(fifo_level),    32'(exp_q.size()));
    chk("word_cnt",   32'(word_cnt),      32'(m_word_cnt));
    chk("frame_err",  32'(frame_err_cnt), 32'(m_err_cnt));
    chk("overflow",   32'(overflow_cnt),  32'(m_ovf_cnt));
  endtask

  // driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk_40MHz);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; rd_en = 1'b0; route_data_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits);
    for (int i = W - 1; i >= W - nbits; i--) begin
      valid_in = 1'b1;
      route_data_in = w[i];
      tick();
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits(w, W);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_in = 1'b0; rd_en = 1'b0; route_data_in = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          trunc;
    logic [W-1:0] word;
    logic [W-1:0] exp_data;
    logic [7:0]   exp_err;
  } vec_t;

  vec_t         tbl[6];
  logic [W-1:0] words[10];

  initial begin
    tbl[0] = '{0,  28'hA5C3F01, 28'hA5C3F01, 8'd0};
    tbl[1] = '{13, 28'h1234567, 28'h1234567, 8'd1};
    tbl[2] = '{0,  28'h0000001, 28'h0000001, 8'd1};
    tbl[3] = '{27, 28'hFFFFFFF, 28'hFFFFFFF, 8'd2};
    tbl[4] = '{1,  28'h8000000, 28'h8000000, 8'd3};
    tbl[5] = '{0,  28'h0ABCDEF, 28'h0ABCDEF, 8'd3};

    rst_n = 1'b0; valid_in = 1'b0; rd_en = 1'b0; route_data_in = 1'b0;
    model_reset();
    #3;
    chk("reset rd_data",    32'(rd_data),    32'h0);
    chk("reset fifo_empty", 32'(fifo_empty), 32'h1);
    chk("reset dbg_state",  32'(dbg_state),  32'(ST_IDLE));
    do_reset();

    // table-driven single words, optionally preceded by a truncated frame
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].trunc > 0) begin
        send_bits(W'($urandom), tbl[t].trunc);
        idle(1);
      end
      send_word(tbl[t].word);
      valid_in = 1'b0;
      chk("latency empty", 32'(fifo_empty), 32'h1);
      idle(1);
      chk("tbl level", 32'(fifo_level), 32'd1);
      chk("tbl frame_err", 32'(frame_err_cnt), 32'(tbl[t].exp_err));
      rd_en = 1'b1;
      tick();
      chk("tbl rd_valid", 32'(rd_valid), 32'h1);
      chk("tbl rd_data", 32'(rd_data), 32'(tbl[t].exp_data));
      idle(1);
      chk("tbl rd_valid drop", 32'(rd_valid), 32'h0);
      chk("tbl rd_data hold", 32'(rd_data), 32'(tbl[t].exp_data));
    end
    rd_en = 1'b1; tick();
    chk("empty pop ignored", 32'(rd_valid), 32'h0);
    idle(1);

    // three back-to-back words
    do_reset();
    send_word(28'h0000001);
    send_word(28'hFFFFFFF);
    send_word(28'h8000000);
    idle(1);
    chk("b2b level", 32'(fifo_level), 32'd3);
    chk("b2b frame_err", 32'(frame_err_cnt), 32'd0);
    rd_en = 1'b1; tick(); chk("b2b w0", 32'(rd_data), 32'h0000001);
    tick(); chk("b2b w1", 32'(rd_data), 32'hFFFFFFF);
    tick(); chk("b2b w2", 32'(rd_data), 32'h8000000);
    idle(1);

    // ten words with no reads: overflow by two
    do_reset();
    for (int i = 0; i < 10; i++) begin
      words[i] = W'($urandom);
      send_word(words[i]);
    end
    idle(1);
    chk("ovf full", 32'(fifo_full), 32'h1);
    chk("ovf count", 32'(overflow_cnt), 32'd2);
    chk("ovf word_cnt", 32'(word_cnt), 32'd8);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ovf drain", 32'(rd_data), 32'(words[i]));
    end
    idle(1);
    chk("ovf drained", 32'(fifo_empty), 32'h1);

    // full FIFO: push and pop on the same edge
    do_reset();
    for (int i = 0; i < 9; i++) words[i] = W'($urandom);
    for (int i = 0; i < 8; i++) send_word(words[i]);
    idle(1);
    send_word(words[8]);
    valid_in = 1'b0; rd_en = 1'b1;
    tick();
    chk("simul rd_valid", 32'(rd_valid), 32'h1);
    chk("simul rd_data", 32'(rd_data), 32'(words[0]));
    chk("simul level", 32'(fifo_level), 32'd8);
    chk("simul overflow", 32'(overflow_cnt), 32'd0);
    chk("simul word_cnt", 32'(word_cnt), 32'd9);
    idle(1);

    // reset mid-frame with words stored
    do_reset();
    for (int i = 0; i < 3; i++) send_word(W'($urandom));
    send_bits(28'h5555555, 20);
    #2;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("mid rst rd_valid", 32'(rd_valid), 32'h0);
    chk("mid rst empty", 32'(fifo_empty), 32'h1);
    chk("mid rst level", 32'(fifo_level), 32'h0);
    chk("mid rst word_cnt", 32'(word_cnt), 32'h0);
    chk("mid rst state", 32'(dbg_state), 32'(ST_IDLE));
    valid_in = 1'b0;
    tick();
    rst_n = 1'b1;
    send_word(28'h2468ACE);
    idle(1);
    chk("post rst word_cnt", 32'(word_cnt), 32'd1);
    rd_en = 1'b1; tick();
    chk("post rst data", 32'(rd_data), 32'h2468ACE);
    idle(1);

    // random traffic in epochs with different read pressure
    do_reset();
    for (int ep = 0; ep < 4; ep++) begin
      for (int c = 0; c < 700; c++) begin
        valid_in      = ($urandom_range(0, 19) != 0);
        route_data_in = 1'($urandom);
        rd_en         = ($urandom_range(0, 7) < 2 * ep);
        tick();
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/route_data_deser.md
# route_data_deser

Receive-side deserializer for the pixel-array readout serial link. It samples the single-bit `route_data_proc` line, qualified by `valid_out` from the chip's parallel-to-serial stage, and rebuilds 28-bit route words. Completed words go into a small FIFO that the readout/LVDS framing logic drains through a read handshake. It sits directly downstream of the digital top's serial output, on the same 40 MHz domain.

## Interface
Parameters:
- `WORD_W`, 28, width of one route word (matches `route_data_proc_in`).
- `FIFO_DEPTH`, 8, FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk_40MHz`  in  1  sole clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  serial qualifier (the top's `valid_out`).
- `route_data_in`  in  1  serial data (the top's `route_data_proc`), MSB first.
- `rd_en`  in  1  read request from the consumer.
- `rd_data`  out  WORD_W  word popped from the FIFO.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `fifo_empty`  out  1  FIFO holds no words.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH words.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  current occupancy.
- `word_cnt`  out  16  count of accepted words; wraps at 0xFFFF→0.
- `frame_err_cnt`  out  8  count of truncated frames; saturates at 255.
- `overflow_cnt`  out  8  count of words dropped because the FIFO was full; saturates at 255.

## Operation
- Link protocol:
  - A word is WORD_W consecutive cycles with `valid_in`=1.
  - One bit is sampled per cycle, MSB first.
  - Back-to-back words are allowed: if `valid_in` stays high after bit 0, the next cycle is the MSB of the next word.
- FSM:
  - `IDLE`: when `valid_in`=1, shift in the bit, set `bit_cnt`=1 and go to `SHIFT`.
  - `SHIFT`, `valid_in`=1: shift in the bit and increment `bit_cnt`.
    - When the bit just shifted is bit index WORD_W-1, issue a push, clear `bit_cnt`, and go to `IDLE`.
    - Continuing `valid_in` then starts the next word with no gap, because `IDLE` samples in the same cycle it is entered.
  - `SHIFT`, `valid_in`=0: discard the partial word, increment `frame_err_cnt` (saturating), clear `bit_cnt`, go to `IDLE`.
- Push:
  - FIFO not full, or full with a simultaneous successful pop: write the word and increment `word_cnt`.
  - Otherwise: drop the word and increment `overflow_cnt` (saturating).
- Pop:
  - `rd_en`=1 and FIFO not empty: read the oldest entry into the `rd_data` register and raise `rd_valid` for 1 cycle.
  - `rd_en` on an empty FIFO is ignored: no error, and `rd_data` holds its last value.
- Simultaneous push and pop: both take effect and `fifo_level` is unchanged. A pop never returns the word being pushed in the same cycle.
- Reset is allowed mid-frame or with the FIFO occupied. It clears the FSM, `bit_cnt`, the pointers and all counters, and drops the partial word and FIFO contents.

## Timing
- Reset values:
  - `rd_data`=0, `rd_valid`=0.
  - `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0.
  - All counters 0; FSM in `IDLE`.
- Word latency: the last bit is sampled at edge N. The FIFO write happens at edge N+1, so `fifo_empty` falls and `word_cnt`/`fifo_level` update after edge N+1.
- Read latency: `rd_en` sampled high at edge M (FIFO non-empty) gives `rd_data`/`rd_valid` valid after edge M, for one cycle.
- Sustained throughput is 1 word per WORD_W cycles. A consumer asserting `rd_en` continuously never overflows.
- All status outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package holds:
  - `ROUTE_WORD_W`=28.
  - The FSM state encoding (`ST_IDLE`, `ST_SHIFT`).
  - Saturating-increment helper constants, e.g. `CNT8_MAX`=8'hFF.
- One sub-module: `route_sync_fifo`, a parameterised synchronous FIFO.
  - Pointers carry an extra wrap bit; full/empty are derived from the pointers.
  - Its ports are push/pop/data/level.
- Deserializer shift register, FSM and counters live in the top module.

## Test plan
- Reset, then 28 cycles of valid, MSB first, carrying 28'hA5C3_F01 → one push; `word_cnt`=1; `fifo_level`=1. Then `rd_en` → `rd_data`=28'hA5C3_F01 with `rd_valid` high for one cycle.
- Three back-to-back words (84 continuous valid cycles) carrying 28'h0000001, 28'hFFFFFFF, 28'h8000000 → popped in that order; `frame_err_cnt`=0.
- Valid drops after 13 bits, followed by a full word carrying 28'h1234567 → `frame_err_cnt`=1; only 28'h1234567 is stored.
- 10 words with no reads (FIFO_DEPTH=8) → `fifo_full`=1, `overflow_cnt`=2, `word_cnt`=8. Popping all 8 returns words 1–8 in order.
- FIFO full, a word completes in the same cycle as `rd_en` → both succeed; `fifo_level` stays 8; `overflow_cnt` unchanged.
- `rst_n` asserted at bit 20 with 3 words stored → all outputs return to reset values immediately. A new 28-bit word after release is received correctly; `word_cnt`=1.
